// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if
//   Bundles the pattern generator's control inputs and its video stream
//   outputs.
//   Port summary:
//     I_pix_en      pixel enable (one pixel per clk where high)
//     I_mode        pattern select: 0 bars, 1 gradient, 2 checker, 3 solid
//     I_solid_rgb   {R,G,B} colour used by mode 3
//     O_rgb_*       DE / HS / VS / R / G / B video stream
//     O_x, O_y      counter position of the pixel now on the outputs
//     O_frame_start one-clk pulse with pixel (0,0)
//     O_frame_cnt   completed-frame count
//
// Handshake: there is no valid/ready pair. I_pix_en is a one-way qualifier.
// On every clk where it is high, the generator consumes one pixel slot and
// presents that pixel one clk later. The stream cannot be back-pressured.
// On every clk where it is low, all outputs hold, except O_frame_start,
// which returns to 0.
//
// master: the source of the control inputs (a testbench or system glue).
// slave:  the generator itself.
interface video_pattern_gen_if;
  logic        I_pix_en;
  logic [1:0]  I_mode;
  logic [23:0] I_solid_rgb;
  logic        O_rgb_de;
  logic        O_rgb_hs;
  logic        O_rgb_vs;
  logic [7:0]  O_rgb_r;
  logic [7:0]  O_rgb_g;
  logic [7:0]  O_rgb_b;
  logic [11:0] O_x;
  logic [11:0] O_y;
  logic        O_frame_start;
  logic [15:0] O_frame_cnt;

  modport master (
    output I_pix_en, I_mode, I_solid_rgb,
    input  O_rgb_de, O_rgb_hs, O_rgb_vs, O_rgb_r, O_rgb_g, O_rgb_b,
    input  O_x, O_y, O_frame_start, O_frame_cnt
  );

  modport slave (
    input  I_pix_en, I_mode, I_solid_rgb,
    output O_rgb_de, O_rgb_hs, O_rgb_vs, O_rgb_r, O_rgb_g, O_rgb_b,
    output O_x, O_y, O_frame_start, O_frame_cnt
  );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Parametrised video timing and test-pattern generator. It produces an
//   RGB/DE/HS/VS stream. It also outputs pixel coordinates and a frame
//   counter.
//   Ports:
//     clk  single clock
//     rst  synchronous, active-high reset
//     bus  video_pattern_gen_if.slave (control inputs and video outputs)
//   Every output is registered. Each one shows the pixel that was sampled
//   on the previous enabled clk edge.
module video_pattern_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int BAR_W       = 100,
  parameter int CHECK_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  video_pattern_gen_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        BAR_W == 0 || CHECK_SHIFT == 0 || CHECK_SHIFT > 11 ||
        H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_params
      $error("video_pattern_gen: illegal parameter set");
    end
  endgenerate

  // Each back porch is at least 1, so every sync end still fits in 12 bits.
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam int BCW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(BAR_W - 1);

  logic [11:0]    hc;
  logic [11:0]    vc;
  logic [1:0]     mode_q;
  logic [2:0]     bi;
  logic [BCW-1:0] bc;
  logic [15:0]    frame_cnt;

  logic        first_px;
  logic [1:0]  mode_eff;
  logic        de;
  logic        hs_on;
  logic        vs_on;
  logic [23:0] bar_rgb;
  logic [23:0] pix_rgb;

  assign bus.O_frame_cnt = frame_cnt;

  always_comb begin
    first_px = (hc == 12'd0) && (vc == 12'd0);
    // Pixel (0,0) is the cycle that latches I_mode, so that pixel already
    // uses the new mode. This keeps a mode switch on a frame boundary.
    mode_eff = first_px ? bus.I_mode : mode_q;
    de       = (hc < H_ACT) && (vc < V_ACT);
    hs_on    = (hc >= HS_BEG) && (hc < HS_END);
    vs_on    = (vc >= VS_BEG) && (vc < VS_END);

    bar_rgb = 24'h000000;
    case (bi)
      3'd0:    bar_rgb = 24'hFF0000;
      3'd1:    bar_rgb = 24'h00FF00;
      3'd2:    bar_rgb = 24'h0000FF;
      3'd3:    bar_rgb = 24'hFFFF00;
      3'd4:    bar_rgb = 24'h00FFFF;
      3'd5:    bar_rgb = 24'hFF00FF;
      3'd6:    bar_rgb = 24'h808080;
      default: bar_rgb = 24'h000000;
    endcase

    pix_rgb = 24'h000000;
    case (mode_eff)
      2'd0:    pix_rgb = bar_rgb;
      2'd1:    pix_rgb = {hc[7:0], vc[7:0], frame_cnt[7:0]};
      2'd2:    pix_rgb = (hc[CHECK_SHIFT] ^ vc[CHECK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      default: pix_rgb = bus.I_solid_rgb;
    endcase
    if (!de) pix_rgb = 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc                <= 12'd0;
      vc                <= 12'd0;
      mode_q            <= 2'd0;
      bi                <= 3'd0;
      bc                <= '0;
      frame_cnt         <= 16'd0;
      bus.O_rgb_de      <= 1'b0;
      bus.O_rgb_hs      <= ~HS_POL;
      bus.O_rgb_vs      <= ~VS_POL;
      bus.O_rgb_r       <= 8'd0;
      bus.O_rgb_g       <= 8'd0;
      bus.O_rgb_b       <= 8'd0;
      bus.O_x           <= 12'd0;
      bus.O_y           <= 12'd0;
      bus.O_frame_start <= 1'b0;
    end else begin
      // The frame-start pulse never holds across a disabled clk.
      bus.O_frame_start <= 1'b0;
      if (bus.I_pix_en) begin
        bus.O_rgb_de      <= de;
        bus.O_rgb_hs      <= hs_on ? HS_POL : ~HS_POL;
        bus.O_rgb_vs      <= vs_on ? VS_POL : ~VS_POL;
        bus.O_rgb_r       <= pix_rgb[23:16];
        bus.O_rgb_g       <= pix_rgb[15:8];
        bus.O_rgb_b       <= pix_rgb[7:0];
        bus.O_x           <= hc;
        bus.O_y           <= vc;
        bus.O_frame_start <= first_px;
        if (first_px) mode_q <= bus.I_mode;

        if (hc == H_LAST) begin
          hc <= 12'd0;
          bi <= 3'd0;
          bc <= '0;
          if (vc == V_LAST) begin
            vc        <= 12'd0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            vc <= vc + 12'd1;
          end
        end else begin
          hc <= hc + 12'd1;
          // The bar index follows hc / BAR_W through a sub-counter, so no
          // divider is needed. It saturates on the last bar.
          if (bc == BC_LAST) begin
            bc <= '0;
            if (bi != 3'd7) bi <= bi + 3'd1;
          end else begin
            bc <= bc + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//   Self-checking bench for video_pattern_gen with a reduced timing set
//   (14 x 7 pixels per frame). A second instance uses inverted sync
//   polarity and shares the same inputs.
module tb_video_pattern_gen;
  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 14
  localparam int VT = VA + VF + VSW + VB;   // 7
  localparam int FRAME = HT * VT;           // 98
  localparam int BW = 1;
  localparam int CS = 1;
  localparam int W = 52;  // {de, hs, vs, r, g, b, x, y, fs}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_pattern_gen_if bus ();
  video_pattern_gen_if bus_n ();
  assign bus_n.I_pix_en    = bus.I_pix_en;
  assign bus_n.I_mode      = bus.I_mode;
  assign bus_n.I_solid_rgb = bus.I_solid_rgb;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .BAR_W(BW), .CHECK_SHIFT(CS)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .BAR_W(BW), .CHECK_SHIFT(CS)
  ) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: the expected mode-0 pixel stream from reset, one entry per pixel.
  logic [W-1:0] exp_q[$];

  // Reference model state
  int           p;         // enabled pixels since reset
  logic [1:0]   m_mode;    // mode of the current frame
  logic [W-1:0] exp_w;     // expected output word
  logic [15:0]  exp_fcnt;  // expected frame count

  logic [23:0] bar_tab [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                               24'h00FFFF, 24'hFF00FF, 24'h808080, 24'h000000};

  function automatic logic [W-1:0] dut_word();
    return {bus.O_rgb_de, bus.O_rgb_hs, bus.O_rgb_vs, bus.O_rgb_r, bus.O_rgb_g,
            bus.O_rgb_b, bus.O_x, bus.O_y, bus.O_frame_start};
  endfunction

  // The expected output for the pp-th pixel after reset, computed from
  // position arithmetic.
  function automatic logic [W-1:0] model_word(int pp, logic [1:0] md, logic [23:0] solid);
    int hc, vc, fr, bar;
    logic de, hs, vs, fs;
    logic [23:0] rgb;
    hc = pp % HT;
    vc = (pp / HT) % VT;
    fr = pp / FRAME;
    de = (hc < HA) && (vc < VA);
    hs = (hc >= HA + HF) && (hc < HA + HF + HSW);
    vs = (vc >= VA + VF) && (vc < VA + VF + VSW);
    fs = (hc == 0) && (vc == 0);
    case (md)
      2'd0: begin
        bar = hc / BW;
        if (bar > 7) bar = 7;
        rgb = bar_tab[bar];
      end
      2'd1:    rgb = {8'(hc), 8'(vc), 8'(fr)};
      2'd2:    rgb = ((((hc >> CS) ^ (vc >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: rgb = solid;
    endcase
    if (!de) rgb = 24'h000000;
    return {de, hs, vs, rgb, 12'(hc), 12'(vc), fs};
  endfunction

  // Driver: applies one clk with the given enable, then moves the model forward.
  task automatic pix(input bit en);
    bus.I_pix_en = en;
    @(posedge clk);
    #1;
    if (en) begin
      if (p % FRAME == 0) m_mode = bus.I_mode;
      exp_w = model_word(p, m_mode, bus.I_solid_rgb);
      p++;
      exp_fcnt = 16'(p / FRAME);
    end else begin
      exp_w[0] = 1'b0;
    end
  endtask

  // Reset is applied with the enable high; reset takes priority.
  task automatic do_reset();
    bus.I_pix_en = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p = 0;
    m_mode = 2'd0;
    exp_w = '0;
    exp_fcnt = 16'd0;
  endtask

  task automatic test_reset();
    bus.I_mode = 2'd0;
    do_reset();
    n_vec++;
    if (dut_word() !== exp_w) begin
      n_err++; $display("FAIL reset_word: got %h want %h", dut_word(), exp_w);
    end
    n_vec++;
    if (bus.O_frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_fcnt: got %h want 0000", bus.O_frame_cnt);
    end
    n_vec++;
    if ({bus_n.O_rgb_hs, bus_n.O_rgb_vs} !== 2'b11) begin
      n_err++; $display("FAIL reset_sync_inv: got %b want 11", {bus_n.O_rgb_hs, bus_n.O_rgb_vs});
    end
    pix(1'b0);
    n_vec++;
    if (dut_word() !== exp_w) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", dut_word(), exp_w);
    end
  endtask

  task automatic test_mode0_constant();
    int last_fs, fs_cnt, de_cnt;
    last_fs = -1; fs_cnt = 0; de_cnt = 0;
    bus.I_mode = 2'd0;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      pix(1'b1);
      exp_q.push_back(exp_w);
      n_vec++;
      if (dut_word() !== exp_w) begin
        n_err++; $display("FAIL mode0_px%0d: got %h want %h", i, dut_word(), exp_w);
      end
      n_vec++;
      if (bus.O_frame_cnt !== exp_fcnt) begin
        n_err++; $display("FAIL mode0_fcnt%0d: got %h want %h", i, bus.O_frame_cnt, exp_fcnt);
      end
      n_vec++;
      if ({bus_n.O_rgb_hs, bus_n.O_rgb_vs} !== ~{exp_w[50], exp_w[49]}) begin
        n_err++; $display("FAIL inv_sync_px%0d: got %b want %b", i,
                          {bus_n.O_rgb_hs, bus_n.O_rgb_vs}, ~{exp_w[50], exp_w[49]});
      end
      if (i < FRAME && bus.O_rgb_de === 1'b1) de_cnt++;
      if (bus.O_frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_vec++;
          if (i - last_fs != FRAME) begin
            n_err++; $display("FAIL fs_period: got %0d want %0d", i - last_fs, FRAME);
          end
        end
        last_fs = i;
        fs_cnt++;
      end
    end
    n_vec++;
    if (fs_cnt != 3) begin
      n_err++; $display("FAIL fs_count: got %0d want 3", fs_cnt);
    end
    n_vec++;
    if (de_cnt != HA * VA) begin
      n_err++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA);
    end
  endtask

  task automatic test_random_enable();
    logic [W-1:0] want, prev;
    int guard;
    bus.I_mode = 2'd0;
    do_reset();
    prev = '0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      bit en;
      en = ($urandom_range(0, 1) == 1);
      pix(en);
      if (en) want = exp_q.pop_front();
      else    want = {prev[W-1:1], 1'b0};
      prev = want;
      n_vec++;
      if (dut_word() !== want) begin
        n_err++; $display("FAIL rand_en_cyc%0d: got %h want %h", guard, dut_word(), want);
      end
      guard++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_en_timeout: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_mode_switch();
    int solid_cnt;
    solid_cnt = 0;
    bus.I_mode = 2'd0;
    bus.I_solid_rgb = 24'h000000;
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == HT + 3) begin
        bus.I_mode = 2'd3;
        bus.I_solid_rgb = 24'h123456;
      end
      pix(1'b1);
      n_vec++;
      if (dut_word() !== exp_w) begin
        n_err++; $display("FAIL switch_px%0d: got %h want %h", i, dut_word(), exp_w);
      end
      if (i >= FRAME && bus.O_rgb_de === 1'b1 &&
          {bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b} === 24'h123456) solid_cnt++;
    end
    n_vec++;
    if (solid_cnt != HA * VA) begin
      n_err++; $display("FAIL switch_solid_count: got %0d want %0d", solid_cnt, HA * VA);
    end
  endtask

  task automatic test_gradient();
    bus.I_mode = 2'd1;
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      pix(1'b1);
      n_vec++;
      if (dut_word() !== exp_w) begin
        n_err++; $display("FAIL grad_px%0d: got %h want %h", i, dut_word(), exp_w);
      end
      if (i % FRAME == 0) begin
        n_vec++;
        if (bus.O_rgb_b !== 8'(i / FRAME)) begin
          n_err++; $display("FAIL grad_b_frame%0d: got %h want %h", i / FRAME, bus.O_rgb_b, 8'(i / FRAME));
        end
      end
      if ((i % FRAME) / HT == 2 && (i % HT) < HA) begin
        n_vec++;
        if (bus.O_rgb_r !== 8'(i % HT)) begin
          n_err++; $display("FAIL grad_r_line2: got %h want %h", bus.O_rgb_r, 8'(i % HT));
        end
      end
    end
  endtask

  task automatic test_checker();
    bus.I_mode = 2'd2;
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      pix(1'b1);
      n_vec++;
      if (dut_word() !== exp_w) begin
        n_err++; $display("FAIL check_px%0d: got %h want %h", i, dut_word(), exp_w);
      end
      if (i == 2) begin
        n_vec++;
        if ({bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b} !== 24'hFFFFFF) begin
          n_err++; $display("FAIL check_2_0: got %h want FFFFFF", {bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b});
        end
      end
      if (i == 2 * HT + 2) begin
        n_vec++;
        if ({bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b} !== 24'h000000) begin
          n_err++; $display("FAIL check_2_2: got %h want 000000", {bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.I_mode = 2'd0;
    do_reset();
    for (int i = 0; i < FRAME + 2 * HT + 6; i++) pix(1'b1);
    n_vec++;
    if (dut_word() !== exp_w || exp_w[24:1] !== {12'd5, 12'd2}) begin
      n_err++; $display("FAIL midrst_pre: got %h want %h", dut_word(), exp_w);
    end
    n_vec++;
    if (bus.O_frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL midrst_pre_fcnt: got %h want 0001", bus.O_frame_cnt);
    end
    do_reset();
    n_vec++;
    if (dut_word() !== '0) begin
      n_err++; $display("FAIL midrst_word: got %h want 0", dut_word());
    end
    n_vec++;
    if (bus.O_frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL midrst_fcnt: got %h want 0000", bus.O_frame_cnt);
    end
    pix(1'b1);
    n_vec++;
    if (dut_word() !== exp_w || exp_w[24:0] !== {12'd0, 12'd0, 1'b1}) begin
      n_err++; $display("FAIL midrst_first: got %h want %h", dut_word(), exp_w);
    end
  endtask

  initial begin
    bus.I_pix_en = 1'b0;
    bus.I_mode = 2'd0;
    bus.I_solid_rgb = 24'h000000;
    p = 0;
    m_mode = 2'd0;
    exp_w = '0;
    exp_fcnt = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mode0_constant();
    test_random_enable();
    test_mode_switch();
    test_gradient();
    test_checker();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised video timing and test-pattern generator. It is the successor to the fixed 800x600 DVI receiver simulation model. It produces the same RGB/DE/HS/VS stream that the DVI receiver delivers to the matrix scaler, so downstream logic can be simulated or bench-tested on hardware without an HDMI source. Compared with the fixed model it adds:
- full porch/sync/polarity parametrisation;
- a pixel clock-enable in place of an internal divider;
- four runtime-selectable patterns, switched glitch-free at frame boundaries;
- pixel coordinate and frame counter outputs.

## Interface
Parameters:
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch (pixels)
- H_SYNC, 128: horizontal sync width (pixels)
- H_BP, 88: horizontal back porch (pixels)
- V_ACTIVE, 600: visible lines per frame
- V_FP, 1: vertical front porch (lines)
- V_SYNC, 4: vertical sync width (lines)
- V_BP, 23: vertical back porch (lines)
- HS_POL, 1: active level of O_rgb_hs
- VS_POL, 1: active level of O_rgb_vs
- BAR_W, 100: colour-bar width in pixels
- CHECK_SHIFT, 4: checker cell size is 2^CHECK_SHIFT pixels

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- I_pix_en  in  1  pixel enable; one pixel is produced per clk where high
- I_mode  in  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 solid
- I_solid_rgb  in  24  {R,G,B} colour for mode 3
- O_rgb_de  out  1  active-video flag
- O_rgb_hs  out  1  horizontal sync, polarity HS_POL
- O_rgb_vs  out  1  vertical sync, polarity VS_POL
- O_rgb_r / O_rgb_g / O_rgb_b  out  8 each  pixel colour
- O_x  out  12  horizontal counter value of the current output pixel
- O_y  out  12  vertical counter value of the current output pixel
- O_frame_start  out  1  single-clk pulse marking pixel (0,0)
- O_frame_cnt  out  16  completed-frame count, wraps

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration fails if any parameter is 0, if H_TOTAL > 4096, or if V_TOTAL > 4096.
- Counters hc and vc are 12 bits and reset to 0. They advance only on clk edges where I_pix_en = 1:
  - hc wraps from H_TOTAL-1 to 0;
  - vc increments on each hc wrap and wraps from V_TOTAL-1 to 0.
- Decode of (hc, vc):
  - DE = hc < H_ACTIVE and vc < V_ACTIVE;
  - HS is active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC;
  - VS is active for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC;
  - VS changes on the pixel where hc = 0.
- Mode latch: mode_q loads I_mode only on an enabled cycle with hc = 0 and vc = 0. Reset value is 0. A mid-frame change of I_mode takes effect from the next frame's first pixel.
- Colour bars (mode 0):
  - bar index bi and sub-counter bc are sequential. Both clear at hc = 0; bc counts to BAR_W-1 and then increments bi.
  - bi saturates at 7; no divider is used.
  - Colours for bi 0..7: FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, 808080, 000000.
- Gradient (mode 1): R = hc[7:0], G = vc[7:0], B = frame_cnt[7:0].
- Checker (mode 2): FFFFFF if hc[CHECK_SHIFT] XOR vc[CHECK_SHIFT], else 000000.
- Solid (mode 3): I_solid_rgb.
- RGB is forced to 000000 whenever DE = 0, in every mode.
- Frame counter: O_frame_cnt increments on the enabled cycle with hc = H_TOTAL-1 and vc = V_TOTAL-1. It wraps from FFFF to 0000.

## Timing
- All outputs are registered. Latency is 1 clk from the enabled edge that samples (hc, vc) to the outputs reflecting that pixel.
- O_x/O_y equal the sampled hc/vc.
- When I_pix_en = 0, all outputs hold their values, except O_frame_start.
- O_frame_start:
  - high for exactly one clk, in the output cycle for pixel (0,0);
  - forced 0 on the next clk, even if I_pix_en stays 0.
- Output reset values (rst = 1 at a clk edge):
  - O_rgb_de = 0, O_rgb_hs = ~HS_POL, O_rgb_vs = ~VS_POL;
  - RGB = 0, O_x = 0, O_y = 0, O_frame_start = 0, O_frame_cnt = 0;
  - mode_q = 0, bi = 0, bc = 0.
- Reset has priority over I_pix_en.
- Reset mid-frame restarts at pixel (0,0). The first enabled cycle after reset releases produces the frame-start pulse and latches I_mode.
- I_pix_en = 1 continuously produces one pixel per clk. Any gap pattern yields the identical pixel sequence.

## Test plan
Small parameter set for all scenarios: H_ACTIVE 8, H_FP 2, H_SYNC 2, H_BP 2 (H_TOTAL 14); V_ACTIVE 4, V_FP 1, V_SYNC 1, V_BP 1 (V_TOTAL 7); BAR_W 1; CHECK_SHIFT 1.
- Reset then I_pix_en = 1 constant, mode 0:
  - O_frame_start pulses every 98 clks;
  - DE is high for 8 of every 14 pixels on lines 0..3;
  - HS is active at hc 10..11, VS on line 5;
  - pixels 0..7 of line 0 are FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, 808080, 000000.
- HS_POL = 0, VS_POL = 0: sync outputs invert, idle level is 1 directly after reset.
- I_mode changed from 0 to 3 (I_solid_rgb = 123456) at pixel (3,1): bars persist to the end of the frame; the next frame shows 123456 on all 32 active pixels and 000000 in blanking.
- I_pix_en toggled at random (~50%): the output sequence, with holds removed, is identical to the constant-enable run; O_frame_start is still exactly 1 clk wide.
- Mode 1 over 3 frames: B = 00, 01, 02 in frames 0, 1, 2; R equals O_x at O_y = 2. Mode 2: pixel (2,0) = FFFFFF and pixel (2,2) = 000000.
- Assert rst at (5,2) for 1 clk: the outputs take their reset values, O_frame_cnt = 0, and the next enabled pixel is (0,0) with O_frame_start = 1.
